// File: rtl/network_mul_arbiter.sv
// Round-robin arbiter that shares one external 2-cycle 16s x 13s multiplier
// among NREQ requesters; a valid/id shadow tracks operations through the multiplier.
module network_mul_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*16-1:0] req_a,
   input  logic [NREQ*13-1:0] req_b,
   output logic [NREQ-1:0]    req_ready,
   output logic               mul_ce,
   output logic [15:0]        mul_din0,
   output logic [12:0]        mul_din1,
   input  logic [28:0]        mul_dout,
   output logic               resp_valid,
   output logic [IDW-1:0]     resp_id,
   output logic [28:0]        resp_data,
   input  logic               resp_ready,
   output logic               busy
);

   logic           v1, v2;
   logic [IDW-1:0] id1, id2;
   logic [IDW-1:0] last_grant;
   logic           gnt_found;
   logic [IDW-1:0] gnt_idx;
   logic [IDW-1:0] cand;
   logic           issue;

   // A response waiting on the sink freezes the multiplier and the shadow together.
   assign mul_ce = ~(v2 & ~resp_ready);

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last_grant) + k) % NREQ);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Gating with reset keeps req_ready low while the block is held in reset.
   assign issue = gnt_found & mul_ce & reset;

   always_comb begin
      req_ready = '0;
      mul_din0  = '0;
      mul_din1  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (issue && (gnt_idx == IDW'(i))) begin
            req_ready[i] = 1'b1;
            mul_din0     = req_a[16*i +: 16];
            mul_din1     = req_b[13*i +: 13];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1         <= 1'b0;
         v2         <= 1'b0;
         id1        <= '0;
         id2        <= '0;
         last_grant <= IDW'(NREQ - 1);
      end else begin
         if (mul_ce) begin
            v1  <= issue;
            id1 <= gnt_idx;
            v2  <= v1;
            id2 <= id1;
         end
         if (issue) begin
            last_grant <= gnt_idx;
         end
      end
   end

   assign resp_valid = v2;
   assign resp_id    = id2;
   assign resp_data  = mul_dout;
   assign busy       = v1 | v2;

endmodule

// File: doc/network_mul_arbiter.md
NETWORK_MUL_ARBITER -- requirements
Module: network_mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter IDW, default 2: requester-index width; IDW SHALL equal ceil(log2(NREQ)).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NREQ  per-requester operand-pair valid.
REQ-006 req_a  in  NREQ*16  per-requester signed multiplicand; requester i in bits [16i+15:16i].
REQ-007 req_b  in  NREQ*13  per-requester signed multiplier; requester i in bits [13i+12:13i].
REQ-008 req_ready  out  NREQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 mul_ce  out  1  clock enable to the shared 16s x 13s, 2-cycle multiplier.
REQ-010 mul_din0  out  16  multiplicand to the multiplier.
REQ-011 mul_din1  out  13  multiplier operand to the multiplier.
REQ-012 mul_dout  in  29  multiplier product; valid 2 enabled edges after issue.
REQ-013 resp_valid  out  1  product available.
REQ-014 resp_id  out  IDW  index of the requester that owns resp_data.
REQ-015 resp_data  out  29  signed product.
REQ-016 resp_ready  in  1  sink accepts the response.
REQ-017 busy  out  1  high while any issued operation has not yet been delivered.

Function
REQ-018 The pipeline shadow SHALL hold valid/id pairs (v1,id1) and (v2,id2), advancing only on edges where mul_ce=1: v1<=issue, id1<=grant index, v2<=v1, id2<=id1.
REQ-019 mul_ce SHALL equal NOT(v2 AND NOT resp_ready); a stalled response freezes the multiplier and the shadow together.
REQ-020 The arbiter SHALL grant at most one requester per cycle, and only when mul_ce=1.
REQ-021 Grant order SHALL be round-robin: search starts at (last_grant+1) mod NREQ, wraps, and picks the first requester with req_valid high.
REQ-022 last_grant SHALL update only on an accepted transfer; cycles with no transfer leave it unchanged.
REQ-023 req_ready SHALL be one-hot or zero, combinational from req_valid, last_grant and mul_ce.
REQ-024 Issue SHALL be defined as (any req_ready bit high AND its req_valid high).
REQ-025 mul_din0 and mul_din1 SHALL carry the granted requester's operands, and SHALL be zero when nothing is granted.
REQ-026 resp_valid SHALL equal v2, resp_id SHALL equal id2, and resp_data SHALL equal mul_dout.
REQ-027 resp_data SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-028 Latency SHALL be 2 cycles from the issue edge to resp_valid, with no stalls.
REQ-029 Throughput SHALL be 1 operation per cycle while resp_ready=1.
REQ-030 When resp_ready falls with v1=1 and v2=1, both operations SHALL be retained; no new issue occurs until resp_ready=1.
REQ-031 When resp_valid=1 and resp_ready=1 in the same cycle as an issue, delivery and issue SHALL both complete with no bubble.
REQ-032 busy SHALL equal v1 OR v2.
REQ-033 An operand pair from requester i SHALL NOT be modified by the block; responses SHALL return in issue order.
REQ-034 Products SHALL be full-precision signed 29-bit values, with no truncation or saturation.

Reset
REQ-035 While reset=0: v1, v2, id1 and id2 = 0, and last_grant = NREQ-1, so requester 0 has first priority.
REQ-036 While reset=0: req_ready = 0, resp_valid = 0, busy = 0, and mul_ce = 1.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight operations; no stale response SHALL appear after release.
REQ-038 Multiplier internal registers are not reset; correctness SHALL rely only on the v1/v2 shadow.
REQ-039 The first grant SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-040 Single op: requester 2 issues a=100, b=-3 -> 2 cycles later resp_valid=1, resp_id=2, resp_data=0x1FFFFED4 (-300).
REQ-041 Extremes: a=-32768, b=-4096 -> resp_data=0x08000000; a=32767, b=-4096 -> resp_data=0x18001000.
REQ-042 All 4 requesters hold valid for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; responses arrive in that order on consecutive cycles.
REQ-043 Backpressure: issue 3 ops back-to-back, hold resp_ready=0 for 5 cycles from the first resp_valid -> mul_ce=0 and resp_data stable for those cycles, no req_ready during the stall, then all 3 delivered in order.
REQ-044 Reset asserted with v1=v2=1 -> resp_valid and busy fall immediately; after release, with no requests, resp_valid stays 0 for 4 cycles.
REQ-045 Sparse: only requester 1 valid after requester 3 was last granted -> requester 1 granted in the same cycle, and last_grant becomes 1.
